output_post_data_module: RTL and testbench
==========================================

# output_post_data_module

Write-back side of the PE datapath. Accepts one 272-bit parallel row (34 × 8-bit) from the PE array per handshake and serializes it byte-by-byte into the output ping-pong buffer's write port, addressing a 34 × 34 = 1156-byte frame. At frame end it pulses the ping-pong switch so the downstream reader can take the completed bank.

## Interface
Parameters:
- `BYTES_PER_ROW`, 34, bytes per parallel row.
- `ROWS`, 34, rows per frame.
- `DATA_W`, 8, byte width.
- `ADDR_W`, 16, write-address width.

Ports:
- `dout_clk`  in  1  sole clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  enable; low freezes all state.
- `i_row_data`  in  [0:271]  parallel row; byte k = `i_row_data[8k +: 8]`, so byte 0 is bits [0:7].
- `i_row_vld`  in  1  row valid.
- `o_row_rdy`  out  1  row accept; transfer when `i_row_vld & o_row_rdy` on a rising edge.
- `i_buf_ready`  in  1  buffer write-side ready; low stalls emission.
- `o_wr_en`  out  1  byte write strobe.
- `o_wr_addr`  out  16  byte address, 0..1155.
- `o_wr_data`  out  8  byte data.
- `o_switch_pingpong`  out  1  one-cycle pulse at frame completion.
- `o_frame_done`  out  1  one-cycle pulse, coincident with `o_switch_pingpong`.
- `o_busy`  out  1  high in SHIFT or FRAME_END.

## Operation
- FSM states: IDLE, SHIFT, FRAME_END.
- IDLE:
  - `o_row_rdy = en`.
  - On handshake: latch the row into the shift register, set `byte_cnt = 0`, go to SHIFT.
- SHIFT:
  - Each cycle with `en & i_buf_ready`: `o_wr_en = 1`, `o_wr_data = byte[byte_cnt]`, `o_wr_addr = row_cnt*34 + byte_cnt`, then `byte_cnt++`.
  - With `i_buf_ready = 0` or `en = 0`: `o_wr_en = 0`; counters and data hold.
- Last byte (`byte_cnt == 33`, accepted):
  - If `row_cnt < 33`: `row_cnt++`. Also assert `o_row_rdy` in this same cycle, so back-to-back rows are possible.
    - Handshake taken: reload the shift register, `byte_cnt = 0`, stay in SHIFT.
    - No handshake: go to IDLE.
  - If `row_cnt == 33`: `o_row_rdy = 0`, go to FRAME_END.
- FRAME_END (exactly 1 cycle):
  - Pulse `o_switch_pingpong` and `o_frame_done`.
  - Clear `row_cnt` and the address to 0.
  - Go to IDLE.
- Address arithmetic:
  - Kept as a running 16-bit counter, incremented once per written byte.
  - Must equal `row_cnt*34 + byte_cnt`; no multiplier is needed.
  - Never exceeds 1155. Wraps to 0 only in FRAME_END.
- `o_row_rdy` is 0 in SHIFT except during the accepted last-byte cycle of a non-final row.
- `i_row_data` is ignored unless a handshake occurs.

## Timing
- Reset values: `o_row_rdy=0` (it rises the first cycle after reset if `en=1`), `o_wr_en=0`, `o_wr_addr=0`, `o_wr_data=0`, `o_switch_pingpong=0`, `o_frame_done=0`, `o_busy=0`. State is IDLE; `row_cnt` and `byte_cnt` are 0.
- Write outputs are registered. Byte 0 of a row appears on the port 1 cycle after the handshake edge.
- Throughput without stalls: 34 cycles per row, 1156 cycles of writes per frame plus 1 FRAME_END cycle.
- A stall of N cycles delays all later bytes by exactly N cycles; no byte is dropped or duplicated.
- Reset mid-frame: immediate return to IDLE with counters at 0. The partial frame is abandoned and no switch pulse is issued.
- `en` low during FRAME_END defers the pulse until `en` returns high; the pulse is still exactly 1 cycle.

## Structure
- Shared package holds:
  - `BYTES_PER_ROW`, `ROWS`, `FRAME_BYTES = 1156`.
  - State enum `{IDLE, SHIFT, FRAME_END}`.
  - Byte-index width, 6 bits.
- Sub-module `row_serializer`: 272-bit load/shift register with a byte-select output and a `last_byte` flag.
- Top level owns the FSM, counters, handshake and ping-pong pulse.

## Test plan
- Single row: row 0 with byte k = k, `i_buf_ready=1` → 34 writes on consecutive cycles, addr 0..33 with data 0..33, then `o_row_rdy=1` in IDLE.
- Back-to-back: `i_row_vld` held high with rows 0 and 1 → addr 0..67 written in 68 consecutive cycles with no gap.
- Backpressure: drop `i_buf_ready` for 5 cycles at byte 10 → `o_wr_en=0` for those cycles, then byte 10 is written at addr 10 with no loss.
- Full frame: 34 rows → last write at addr 1155, then a 1-cycle `o_switch_pingpong` and `o_frame_done`, and the next frame's first write is at addr 0.
- Enable freeze: `en=0` for 3 cycles during SHIFT → no writes and no counter change; emission resumes exactly where it stopped.
- Reset mid-frame: assert `rst_n=0` at row 5, byte 7 → all outputs are 0 immediately, no switch pulse, and the next row is written starting at addr 0.

Source files
------------

// File: rtl/output_post_data_module_pkg.sv
// Shared constants and FSM encoding for the PE write-back serializer.
package output_post_data_module_pkg;
   localparam int BYTES_PER_ROW = 34;
   localparam int ROWS          = 34;
   localparam int FRAME_BYTES   = BYTES_PER_ROW * ROWS;
   localparam int BYTE_IDX_W    = 6;

   typedef enum logic [1:0] {IDLE, SHIFT, FRAME_END} state_t;
endpackage

// File: rtl/output_post_data_module_row_serializer.sv
// Holds one parallel row and presents it a byte at a time, byte 0 first.
module row_serializer #(
   parameter int BYTES_PER_ROW = 34,
   parameter int DATA_W        = 8
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              load,
   input  logic                              advance,
   input  logic [0:BYTES_PER_ROW*DATA_W-1]   row_data,
   output logic [DATA_W-1:0]                 byte_data,
   output logic                              last_byte
);
   import output_post_data_module_pkg::*;

   logic [0:BYTES_PER_ROW*DATA_W-1] shift_q;
   logic [BYTE_IDX_W-1:0]           idx_q;

   // Shifting toward index 0 keeps the current byte always in the top slot.
   always_ff @(posedge clk) begin
      if (load)
         shift_q <= row_data;
      else if (advance)
         shift_q <= shift_q << DATA_W;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idx_q <= '0;
      else if (load)
         idx_q <= '0;
      else if (advance)
         idx_q <= last_byte ? '0 : idx_q + 1'b1;
   end

   assign byte_data = shift_q[0:DATA_W-1];
   assign last_byte = (idx_q == BYTE_IDX_W'(BYTES_PER_ROW - 1));
endmodule

// File: rtl/output_post_data_module.sv
// Write-back of PE rows: serializes each 34-byte row into the output
// ping-pong buffer and pulses the bank switch once a full frame is written.
module output_post_data_module #(
   parameter int BYTES_PER_ROW = 34,
   parameter int ROWS          = 34,
   parameter int DATA_W        = 8,
   parameter int ADDR_W        = 16
)(
   input  logic                            dout_clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic [0:BYTES_PER_ROW*DATA_W-1] i_row_data,
   input  logic                            i_row_vld,
   output logic                            o_row_rdy,
   input  logic                            i_buf_ready,
   output logic                            o_wr_en,
   output logic [ADDR_W-1:0]               o_wr_addr,
   output logic [DATA_W-1:0]               o_wr_data,
   output logic                            o_switch_pingpong,
   output logic                            o_frame_done,
   output logic                            o_busy
);
   import output_post_data_module_pkg::*;

   state_t                state_q, state_d;
   logic [BYTE_IDX_W-1:0] row_cnt_q;
   logic [ADDR_W-1:0]     addr_cnt_q;
   logic [DATA_W-1:0]     byte_data;
   logic                  last_byte, emit, last_emit, final_row;
   logic                  handshake, frame_fire, row_rdy;

   assign final_row  = (row_cnt_q == BYTE_IDX_W'(ROWS - 1));
   assign emit       = (state_q == SHIFT) & en & i_buf_ready;
   assign last_emit  = emit & last_byte;
   assign frame_fire = (state_q == FRAME_END) & en;

   // Ready also opens on the accepted last byte of a non-final row so rows
   // can stream back-to-back; held low while reset is asserted.
   assign row_rdy   = rst_n & (((state_q == IDLE) & en) | (last_emit & ~final_row));
   assign o_row_rdy = row_rdy;
   assign handshake = i_row_vld & row_rdy;
   assign o_busy    = (state_q != IDLE);

   row_serializer #(
      .BYTES_PER_ROW (BYTES_PER_ROW),
      .DATA_W        (DATA_W)
   ) u_row_serializer (
      .clk       (dout_clk),
      .rst_n     (rst_n),
      .load      (handshake),
      .advance   (emit),
      .row_data  (i_row_data),
      .byte_data (byte_data),
      .last_byte (last_byte)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (handshake) state_d = SHIFT;
         SHIFT:     if (last_emit) state_d = final_row ? FRAME_END : (handshake ? SHIFT : IDLE);
         FRAME_END: if (en) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Running address replaces row_cnt*34 + byte_cnt; it only wraps at frame end.
   always_ff @(posedge dout_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         row_cnt_q         <= '0;
         addr_cnt_q        <= '0;
         o_wr_en           <= 1'b0;
         o_wr_addr         <= '0;
         o_wr_data         <= '0;
         o_switch_pingpong <= 1'b0;
         o_frame_done      <= 1'b0;
      end else begin
         state_q           <= state_d;
         o_wr_en           <= emit;
         o_switch_pingpong <= frame_fire;
         o_frame_done      <= frame_fire;
         if (emit) begin
            o_wr_addr  <= addr_cnt_q;
            o_wr_data  <= byte_data;
            addr_cnt_q <= addr_cnt_q + 1'b1;
         end else if (frame_fire) begin
            o_wr_addr  <= '0;
            addr_cnt_q <= '0;
         end
         if (last_emit & ~final_row)
            row_cnt_q <= row_cnt_q + 1'b1;
         else if (frame_fire)
            row_cnt_q <= '0;
      end
   end
endmodule

// File: tb/tb_output_post_data_module.sv
// Bench for output_post_data_module: random rows against a byte-stream model.
module tb_output_post_data_module;
   localparam int BPR   = 34;
   localparam int NR    = 34;
   localparam int DW    = 8;
   localparam int AW    = 16;
   localparam int RW    = BPR * DW;
   localparam int FRAME = BPR * NR;

   logic            dout_clk = 1'b0;
   logic            rst_n, en, i_row_vld, o_row_rdy, i_buf_ready;
   logic            o_wr_en, o_switch_pingpong, o_frame_done, o_busy;
   logic [0:RW-1]   i_row_data;
   logic [AW-1:0]   o_wr_addr;
   logic [DW-1:0]   o_wr_data;

   int total = 0, bad = 0;
   int cyc = 0, first_wr = -1, last_wr = -1, first_addr = -1, last_addr = -1;
   int frame_row = 0, exp_pulses = 0, pulses = 0;
   logic prev_sw = 1'b0;
   logic feed_done;
   int exp_addr_q[$];
   int exp_data_q[$];

   output_post_data_module dut (
      .dout_clk          (dout_clk),
      .rst_n             (rst_n),
      .en                (en),
      .i_row_data        (i_row_data),
      .i_row_vld         (i_row_vld),
      .o_row_rdy         (o_row_rdy),
      .i_buf_ready       (i_buf_ready),
      .o_wr_en           (o_wr_en),
      .o_wr_addr         (o_wr_addr),
      .o_wr_data         (o_wr_data),
      .o_switch_pingpong (o_switch_pingpong),
      .o_frame_done      (o_frame_done),
      .o_busy            (o_busy)
   );

   always #5 dout_clk = ~dout_clk;
   always @(posedge dout_clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Every write on the port must be the next byte of the model's stream.
   always @(negedge dout_clk) begin
      if (o_wr_en) begin
         if (exp_addr_q.size() == 0)
            chk("extra_write", int'(o_wr_addr), -1);
         else begin
            chk("wr_addr", int'(o_wr_addr), exp_addr_q.pop_front());
            chk("wr_data", int'(o_wr_data), exp_data_q.pop_front());
         end
         if (first_wr < 0) begin
            first_wr   = cyc;
            first_addr = int'(o_wr_addr);
         end
         last_wr   = cyc;
         last_addr = int'(o_wr_addr);
      end
      if (o_switch_pingpong || o_frame_done) begin
         pulses++;
         chk("frame_done_with_switch", int'(o_frame_done), int'(o_switch_pingpong));
         chk("switch_after_last_addr", last_addr, FRAME - 1);
         chk("switch_single_cycle", int'(prev_sw), 0);
         last_addr = -1;
      end
      prev_sw = o_switch_pingpong;
   end

   function automatic logic [0:RW-1] rand_row();
      logic [0:RW-1] r;
      for (int k = 0; k < BPR; k++) r[8*k +: 8] = 8'($urandom);
      return r;
   endfunction

   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic send_row(input logic [0:RW-1] row);
      int guard = 0;
      i_row_vld  = 1'b1;
      i_row_data = row;
      #1;
      while (!o_row_rdy && guard < 4000) begin
         @(negedge dout_clk);
         #1;
         guard++;
      end
      chk("handshake_seen", int'(o_row_rdy), 1);
      if (o_row_rdy) begin
         for (int k = 0; k < BPR; k++) begin
            exp_addr_q.push_back(frame_row * BPR + k);
            exp_data_q.push_back(int'(row[8*k +: 8]));
         end
         frame_row++;
         if (frame_row == NR) begin
            frame_row = 0;
            exp_pulses++;
         end
      end
      @(negedge dout_clk);
      i_row_vld = 1'b0;
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while ((exp_addr_q.size() != 0 || o_busy) && guard < 5000) begin
         @(negedge dout_clk);
         guard++;
      end
      #1;
      chk(tag, exp_addr_q.size(), 0);
   endtask

   task automatic wait_write(input int addr);
      int guard = 0;
      while (!(o_wr_en && int'(o_wr_addr) == addr) && guard < 3000) begin
         @(negedge dout_clk);
         guard++;
      end
      chk("wait_write_seen", int'(o_wr_addr), addr);
   endtask

   initial begin
      logic [0:RW-1] row;
      int base;
      int nrows;
      rst_n = 1'b0; en = 1'b1; i_row_vld = 1'b0; i_buf_ready = 1'b1; i_row_data = '0;
      repeat (3) @(negedge dout_clk);
      chk("rst_row_rdy", int'(o_row_rdy), 0);
      chk("rst_wr_en", int'(o_wr_en), 0);
      chk("rst_wr_addr", int'(o_wr_addr), 0);
      chk("rst_wr_data", int'(o_wr_data), 0);
      chk("rst_switch", int'(o_switch_pingpong), 0);
      chk("rst_frame_done", int'(o_frame_done), 0);
      chk("rst_busy", int'(o_busy), 0);
      rst_n = 1'b1;
      #1;
      chk("idle_rdy_after_rst", int'(o_row_rdy), 1);
      @(negedge dout_clk);

      // Single row, byte k = k
      for (int k = 0; k < BPR; k++) row[8*k +: 8] = 8'(k);
      first_wr = -1;
      send_row(row);
      drain("single_drain");
      chk("single_first_addr", first_addr, 0);
      chk("single_span", last_wr - first_wr, BPR - 1);
      chk("single_idle_rdy", int'(o_row_rdy), 1);
      chk("single_idle_busy", int'(o_busy), 0);

      // Back-to-back rows
      first_wr = -1;
      send_row(rand_row());
      send_row(rand_row());
      drain("b2b_drain");
      chk("b2b_span", last_wr - first_wr, 2 * BPR - 1);

      // Buffer backpressure for 5 cycles at byte 10
      first_wr = -1;
      base = frame_row * BPR;
      fork
         send_row(rand_row());
         begin
            wait_write(base + 9);
            i_buf_ready = 1'b0;
            repeat (5) begin
               @(negedge dout_clk);
               chk("bp_no_write", int'(o_wr_en), 0);
            end
            i_buf_ready = 1'b1;
            @(negedge dout_clk);
            chk("bp_resume_addr", int'(o_wr_addr), base + 10);
         end
      join
      drain("bp_drain");
      chk("bp_span", last_wr - first_wr, BPR - 1 + 5);

      // Enable freeze for 3 cycles at byte 20
      first_wr = -1;
      base = frame_row * BPR;
      fork
         send_row(rand_row());
         begin
            wait_write(base + 19);
            en = 1'b0;
            repeat (3) begin
               @(negedge dout_clk);
               chk("freeze_no_write", int'(o_wr_en), 0);
               chk("freeze_busy", int'(o_busy), 1);
            end
            en = 1'b1;
            @(negedge dout_clk);
            chk("freeze_resume_addr", int'(o_wr_addr), base + 20);
         end
      join
      drain("freeze_drain");
      chk("freeze_span", last_wr - first_wr, BPR - 1 + 3);

      // Rest of frame 1 with random enable, backpressure and row gaps
      feed_done = 1'b0;
      fork
         begin
            nrows = 0;
            do begin
               repeat ($urandom_range(0, 2)) @(negedge dout_clk);
               send_row(rand_row());
               nrows++;
            end while (frame_row != 0 && nrows < 40);
            feed_done = 1'b1;
         end
         begin
            while (!feed_done) begin
               @(negedge dout_clk);
               en          = ($urandom_range(0, 7) != 0);
               i_buf_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      en = 1'b1;
      i_buf_ready = 1'b1;
      drain("frame1_drain");
      chk("frame1_pulses", pulses, exp_pulses);

      // Frame 2 streamed, with enable low while in FRAME_END
      first_wr = -1;
      fork
         for (int r = 0; r < NR; r++) send_row(rand_row());
         begin
            wait_write(FRAME - 1);
            en = 1'b0;
            repeat (2) begin
               @(negedge dout_clk);
               chk("pulse_deferred", int'(o_switch_pingpong), 0);
               chk("frame_end_busy", int'(o_busy), 1);
            end
            en = 1'b1;
            @(negedge dout_clk);
            chk("pulse_after_en", int'(o_switch_pingpong), 1);
         end
      join
      drain("frame2_drain");
      chk("frame2_first_addr", first_addr, 0);
      chk("frame2_pulses", pulses, exp_pulses);

      // Reset at row 5 byte 7 of frame 3
      for (int r = 0; r < 6; r++) send_row(rand_row());
      wait_write(5 * BPR + 7);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_row_rdy", int'(o_row_rdy), 0);
      chk("mid_rst_wr_en", int'(o_wr_en), 0);
      chk("mid_rst_wr_addr", int'(o_wr_addr), 0);
      chk("mid_rst_wr_data", int'(o_wr_data), 0);
      chk("mid_rst_switch", int'(o_switch_pingpong), 0);
      chk("mid_rst_busy", int'(o_busy), 0);
      exp_addr_q.delete();
      exp_data_q.delete();
      frame_row = 0;
      repeat (2) @(negedge dout_clk);
      rst_n = 1'b1;
      @(negedge dout_clk);
      first_wr = -1;
      send_row(rand_row());
      drain("post_rst_drain");
      chk("post_rst_first_addr", first_addr, 0);
      chk("post_rst_span", last_wr - first_wr, BPR - 1);
      chk("post_rst_pulses", pulses, exp_pulses);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
